multibyte_add_seq: RTL

//   Sequencer upstream of the 8-bit adder: accepts NBYTES-wide add/sub operands, feeds one byte
//   per cycle (LSB first) into an external add8 instance, chains cout->cin across cycles,

---
 rtl/multibyte_add_seq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/multibyte_add_seq.sv
// Byte-serial add/sub sequencer: drives an external 8-bit adder one byte per cycle,
// LSB first, chaining carry across cycles, and presents the assembled result with flags.
module multibyte_add_seq #(
    parameter int NBYTES = 4,
    localparam int W = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         op_sub,
    output logic [7:0]   add_a,
    output logic [7:0]   add_b,
    output logic         add_cin,
    input  logic [7:0]   add_sum,
    input  logic         add_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         carry,
    output logic         overflow,
    output logic         zero,
    output logic         negative
);

    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [IDXW-1:0] idx_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            chain_q;
    logic [W-1:0]    result_q;
    logic [W-1:0]    result_d;
    logic            out_valid_q;
    logic            carry_q;
    logic            overflow_q;
    logic            zero_q;
    logic            negative_q;
    logic            ovf_d;

    // Result with the current adder byte merged in; also used for the zero flag.
    always_comb begin
        result_d = result_q;
        if (state_q == S_RUN) begin
            result_d[32'd8 * idx_q +: 8] = add_sum;
        end else begin
            result_d = result_q;
        end
    end

    // Signed overflow uses the already-inverted B so add and sub share one rule.
    always_comb begin
        ovf_d = (a_q[W-1] == b_q[W-1]) && (add_sum[7] != a_q[W-1]);
    end

    // Adder byte feed: only active while running, quiet zeros otherwise.
    always_comb begin
        add_a   = 8'h00;
        add_b   = 8'h00;
        add_cin = 1'b0;
        case (state_q)
            S_RUN: begin
                add_a   = a_q[32'd8 * idx_q +: 8];
                add_b   = b_q[32'd8 * idx_q +: 8];
                add_cin = chain_q;
            end
            default: begin
                add_a   = 8'h00;
                add_b   = 8'h00;
                add_cin = 1'b0;
            end
        endcase
    end

    // Sequencer FSM with all result/flag outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            chain_q     <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q      <= op_a;
                        b_q      <= op_sub ? ~op_b : op_b;
                        chain_q  <= op_sub;
                        idx_q    <= '0;
                        result_q <= '0;
                        state_q  <= S_RUN;
                    end else begin
                        state_q  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    result_q <= result_d;
                    chain_q  <= add_cout;
                    if (idx_q == LAST_IDX) begin
                        idx_q       <= '0;
                        carry_q     <= add_cout;
                        negative_q  <= add_sum[7];
                        overflow_q  <= ovf_d;
                        zero_q      <= (result_d == {W{1'b0}});
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end else begin
                        state_q     <= S_DONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign negative  = negative_q;

endmodule
